flag_ctx_reg: RTL
=================

// Module: flag_ctx_reg
// PURPOSE
//  Parametrised condition-flag register with a checkpoint stack and a branch-condition evaluator.
//  Sits in Execute after the ALU.
//  Per-flag write enables update the live flags; save/restore push and pop flag snapshots for interrupt/mispredict recovery.
//  cond_true feeds branch resolution.
// PARAMETERS
//  NFLAGS  3  live flag count, >=3; bit0=Z, bit1=N, bit2=V, upper bits general-purpose
//  DEPTH   4  checkpoint stack entries, >=1
// PORTS
//  clk        in   1                  clock, all state updates on rising edge
//  rst        in   1                  synchronous, active-high reset
//  flags_in   in   NFLAGS             new flag values from ALU
//  flags_wen  in   NFLAGS             per-bit write enable
//  save       in   1                  push live flags onto stack
//  restore    in   1                  pop top of stack into live flags
//  err_clr    in   1                  clear sticky ovf/unf
//  cond       in   3                  branch condition code
//  flags_out  out  NFLAGS             live flags
//  cond_true  out  1                  cond satisfied (combinational)
//  depth_cnt  out  $clog2(DEPTH+1)    valid stack entries
//  full       out  1                  depth_cnt==DEPTH
//  empty      out  1                  depth_cnt==0
//  ovf        out  1                  sticky: save attempted while full
//  unf        out  1                  sticky: restore attempted while empty
// BEHAVIOUR
//  Reset (clk edge with rst=1):
//   - flags_out=0, depth_cnt=0, ovf=0, unf=0, stack contents don't-care.
//   - rst overrides all other inputs, including mid-sequence save/restore.
//  Write:
//   - flags_out[i] <= flags_in[i] where flags_wen[i]=1, else hold.
//   - Latency 1 cycle.
//  save (restore=0), not full:
//   - stack[depth_cnt] <= flags_out (pre-write value); depth_cnt+1.
//   - A same-cycle write still updates the live flags.
//  save when full:
//   - Stack and depth unchanged; ovf <= 1; write applies normally.
//  restore (save=0), not empty:
//   - flags_out <= stack[depth_cnt-1]; depth_cnt-1.
//   - Restore beats a same-cycle write: flags_wen is ignored that cycle.
//  restore when empty:
//   - Stack unchanged; unf <= 1; write applies normally.
//  save and restore together:
//   - Stack, depth and ovf/unf unchanged.
//   - Writes apply (net no-op on stack).
//  err_clr:
//   - Clears ovf/unf next edge.
//   - A new error in the same cycle wins, so the flag stays set.
//  full/empty: combinational from depth_cnt. Counter never wraps.
//  cond_true, evaluated on flags F (Z,N,V):
//   000 NE   ~Z
//   001 EQ   Z
//   010 GT   ~Z & ~N
//   011 LT   N
//   100 GTE  Z | (~Z & ~N)
//   101 LTE  N | Z
//   110 OV   V
//   111 UN   1
// CONFIGURATION
//  FLAG_FWD_EN defined:
//   - F = next-state live flags: flags_in where flags_wen=1, else flags_out.
//   - Restore does not forward; F = flags_out in a restore cycle.
//   - Lets a branch use flags set in the same cycle.
//  FLAG_FWD_EN undefined: F = flags_out (registered).
//  No other behaviour differs between builds.
// TESTING
//  1. rst=1 one edge with save/restore/wen all high -> flags_out=0, depth_cnt=0, empty=1, ovf=unf=0.
//  2. Write 3'b101, wen=3'b111; save; write 3'b010; restore -> flags_out=3'b101, depth_cnt=0.
//  3. DEPTH=4: 5 consecutive saves -> depth_cnt=4, full=1, ovf=1 after 5th; err_clr -> ovf=0.
//  4. Restore while empty with flags_in=3'b111, wen=3'b001 -> unf=1, flags_out=3'b001.
//  5. flags_out Z=0,N=0: cond 010 -> cond_true=1; cond 011 -> 0; cond 111 -> 1.
//     With FLAG_FWD_EN and Z written 1 same cycle: cond 001 -> 1 (0 without the macro).
//  6. Save+restore together at depth 2 with a write -> depth stays 2, write lands, no error.

Source files
------------

// File: rtl/flag_ctx_reg.sv
// Condition-flag register with a LIFO checkpoint stack and branch-condition evaluator.
// Build option FLAG_FWD_EN: cond_true sees same-cycle written flags instead of the registered ones.
module flag_ctx_reg #(
  parameter int NFLAGS = 3,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NFLAGS-1:0]          flags_in,
  input  logic [NFLAGS-1:0]          flags_wen,
  input  logic                       save,
  input  logic                       restore,
  input  logic                       err_clr,
  input  logic [2:0]                 cond,
  output logic [NFLAGS-1:0]          flags_out,
  output logic                       cond_true,
  output logic [$clog2(DEPTH+1)-1:0] depth_cnt,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf,
  output logic                       unf
);

  localparam int DW = $clog2(DEPTH+1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [NFLAGS-1:0] flags_q, flags_d;
  logic [DW-1:0]     depth_q, depth_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [NFLAGS-1:0] stack_q [0:(1<<AW)-1];

  logic              save_ok, restore_ok, save_err, restore_err;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [NFLAGS-1:0] wr_next;
  logic [NFLAGS-1:0] eval_flags;
  logic [2:0]        zvn;

  function automatic logic cond_eval(input logic [2:0] c, input logic z,
                                     input logic n, input logic v);
    logic r;
    unique case (c)
      3'b000:  r = ~z;
      3'b001:  r = z;
      3'b010:  r = ~z & ~n;
      3'b011:  r = n;
      3'b100:  r = z | (~z & ~n);
      3'b101:  r = n | z;
      3'b110:  r = v;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  assign full        = (depth_q == DW'(DEPTH));
  assign empty       = (depth_q == '0);
  assign save_ok     = save & ~restore & ~full;
  assign restore_ok  = restore & ~save & ~empty;
  assign save_err    = save & ~restore & full;
  assign restore_err = restore & ~save & empty;
  assign wr_ptr      = AW'(depth_q);
  assign rd_ptr      = AW'(depth_q - DW'(1));
  assign wr_next     = (flags_in & flags_wen) | (flags_q & ~flags_wen);

  always_comb begin
    flags_d = restore_ok ? stack_q[rd_ptr] : wr_next;
    depth_d = depth_q;
    if (save_ok)    depth_d = depth_q + DW'(1);
    if (restore_ok) depth_d = depth_q - DW'(1);
    // A fresh error outranks a same-cycle clear.
    ovf_d = err_clr ? 1'b0 : ovf_q;
    unf_d = err_clr ? 1'b0 : unf_q;
    if (save_err)    ovf_d = 1'b1;
    if (restore_err) unf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (save_ok && !rst) stack_q[wr_ptr] <= flags_q;
  end

`ifdef FLAG_FWD_EN
  // A popped snapshot is not forwarded; the branch sees the current flags then.
  assign eval_flags = restore_ok ? flags_q : wr_next;
`else
  assign eval_flags = flags_q;
`endif

  assign zvn       = eval_flags[2:0];
  assign cond_true = cond_eval(cond, zvn[0], zvn[1], zvn[2]);

  assign flags_out = flags_q;
  assign depth_cnt = depth_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;

endmodule
